// File: rtl/gf180mcu_fd_sc_mcu9t5v0__srseq_pkg.sv
// Shared types and default timing for the set/reset sequencer.
// Imported by the sequencer top and its request synchronizer.
package gf180mcu_fd_sc_mcu9t5v0__srseq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_HOLD = 2'd1,
    SET_HOLD = 2'd2,
    GAP      = 2'd3
  } srseq_state_e;

  localparam int HOLD_CYC_DEF = 4;
  localparam int GAP_CYC_DEF  = 1;
  localparam int CW_DEF       = 4;

  // Request bit positions in the synchronized bundle.
  localparam int REQ_CLR = 1;
  localparam int REQ_SET = 0;
  localparam int REQ_W   = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__srseq_sync.sv
// Two-flop synchronizer for the clear/set request levels.
// Only instantiated when GF180_SRSEQ_SYNC_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__srseq_sync
  import gf180mcu_fd_sc_mcu9t5v0__srseq_pkg::*;
#(
  parameter int W = REQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two stages; both clear so no request is seen during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__srseq.sv
// Clear/set pulse sequencer for negative-edge set/reset flop banks.
// Define GF180_SRSEQ_SYNC_EN to synchronize CLR_REQ/SET_REQ (2 cycles).
module gf180mcu_fd_sc_mcu9t5v0__srseq
  import gf180mcu_fd_sc_mcu9t5v0__srseq_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR_REQ,
  input  logic SET_REQ,
  output logic RN,
  output logic SETN,
  output logic ACK,
  output logic BUSY
);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [REQ_W-1:0] req_raw;
  logic [REQ_W-1:0] req_s;
  logic             clr_req;
  logic             set_req;

  assign req_raw[REQ_CLR] = CLR_REQ;
  assign req_raw[REQ_SET] = SET_REQ;

`ifdef GF180_SRSEQ_SYNC_EN
  gf180mcu_fd_sc_mcu9t5v0__srseq_sync #(
    .W (REQ_W)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (req_raw),
    .q   (req_s)
  );
`else
  assign req_s = req_raw;
`endif

  assign clr_req = req_s[REQ_CLR];
  assign set_req = req_s[REQ_SET];

  srseq_state_e  state;
  srseq_state_e  state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          op_req;
  logic          op_req_nxt;
  logic          ack_nxt;
  logic          rn_nxt;
  logic          setn_nxt;
  logic          busy_nxt;

  // Next state, counter and the registered-output values.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_req_nxt = op_req;
    ack_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        // The ACK cycle doubles as a one-cycle request blackout
        // so a requester still holding its level is not re-served.
        if (!ACK) begin
          if (clr_req) begin
            state_nxt  = CLR_HOLD;
            cnt_nxt    = HOLD_LD;
            op_req_nxt = 1'b1;
          end else if (set_req) begin
            state_nxt  = SET_HOLD;
            cnt_nxt    = HOLD_LD;
            op_req_nxt = 1'b1;
          end
        end
      end
      CLR_HOLD, SET_HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt  = IDLE;
          ack_nxt    = op_req;
          op_req_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Outputs are decoded from the next state so the flops
    // line up with the state they describe; at most one of
    // RN/SETN can be low because the states are exclusive.
    rn_nxt   = (state_nxt != CLR_HOLD);
    setn_nxt = (state_nxt != SET_HOLD);
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counter and output flops; reset starts a power-up clear
  // and drops any SET hold in the same instant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= CLR_HOLD;
      cnt    <= HOLD_LD;
      op_req <= 1'b0;
      RN     <= 1'b0;
      SETN   <= 1'b1;
      ACK    <= 1'b0;
      BUSY   <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_req <= op_req_nxt;
      RN     <= rn_nxt;
      SETN   <= setn_nxt;
      ACK    <= ack_nxt;
      BUSY   <= busy_nxt;
    end
  end

endmodule
